// File: rtl/guess_pkg.sv
// Shared definitions for the game sequencer slice: state encoding, field
// widths and a saturating score increment.
// No ports.
package guess_pkg;

  localparam int SCORE_W = 4;
  localparam int LIVES_W = 3;
  localparam int LEVEL_W = 2;
  localparam int HOLD_W  = 8;

  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CLEAR     = 3'd1,
    ST_PLAY      = 3'd2,
    ST_SHOW_WIN  = 3'd3,
    ST_SHOW_LOSE = 3'd4,
    ST_OVER      = 3'd5
  } game_state_e;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (v == SCORE_MAX) ? v : v + SCORE_W'(1);
  endfunction

endpackage

// File: rtl/game_sequencer_if.sv
// Signal bundle between the game sequencer and its surroundings
// (start button, timebase, guess FSM and score display).
//   start_tick, tick_in, win, lose : into the sequencer
//   fsm_clear, fsm_en              : control to the guess FSM
//   wins, losses, lives, level,
//   game_over                      : score/status out of the sequencer
// Modports: slave = sequencer side, master = stimulus/consumer side.
interface game_sequencer_if;
  import guess_pkg::*;

  logic                 start_tick;
  logic                 tick_in;
  logic                 win;
  logic                 lose;
  logic                 fsm_clear;
  logic                 fsm_en;
  logic [SCORE_W-1:0]   wins;
  logic [SCORE_W-1:0]   losses;
  logic [LIVES_W-1:0]   lives;
  logic [LEVEL_W-1:0]   level;
  logic                 game_over;

  modport slave (
    input  start_tick, tick_in, win, lose,
    output fsm_clear, fsm_en, wins, losses, lives, level, game_over
  );

  modport master (
    output start_tick, tick_in, win, lose,
    input  fsm_clear, fsm_en, wins, losses, lives, level, game_over
  );

endinterface

// File: rtl/tick_divider.sv
// Divides the tick_in pulse stream: tick_out fires on the tick_in that finds
// the counter equal to ratio, after which the counter restarts at 0, so one
// tick_out is produced every (ratio+1) tick_in pulses.
//   clk, rst  : clock, async active-high reset
//   tick_in   : pulse to be divided (already gated by the caller)
//   ratio     : terminal count
//   clear     : synchronous counter clear, suppresses tick_out
//   tick_out  : combinational divided pulse
module tick_divider
  import guess_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               tick_in,
  input  logic [LEVEL_W-1:0] ratio,
  input  logic               clear,
  output logic               tick_out
);

  logic [LEVEL_W-1:0] div_q;
  logic [LEVEL_W-1:0] div_d;

  assign tick_out = tick_in && !clear && (div_q == ratio);

  always_comb begin
    div_d = div_q;
    if (clear || tick_out) begin
      div_d = '0;
    end else if (tick_in) begin
      div_d = div_q + LEVEL_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/game_sequencer.sv
// Round/score sequencer wrapped around a guess FSM. Restarts the guess FSM,
// paces it with a level-dependent step enable, keeps score, and holds each
// round result on screen for SHOW_TICKS timebase pulses.
//   clk, rst : clock, async active-high reset
//   bus      : game_sequencer_if.slave (start_tick, tick_in, win, lose in;
//              fsm_clear, fsm_en, wins, losses, lives, level, game_over out)
//
// state        | meaning
// -------------+--------------------------------------------------
// ST_IDLE      | after reset, waiting for start_tick
// ST_CLEAR     | one-cycle restart of the guess FSM
// ST_PLAY      | round in progress, fsm_en paced by the divider
// ST_SHOW_WIN  | holding a won round result
// ST_SHOW_LOSE | holding a lost round result
// ST_OVER      | no lives left, waiting for start_tick
module game_sequencer
  import guess_pkg::*;
#(
  parameter int LIVES      = 3,
  parameter int SHOW_TICKS = 8,
  parameter int MAX_LEVEL  = 3
) (
  input  logic             clk,
  input  logic             rst,
  game_sequencer_if.slave  bus
);

  localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);
  localparam logic [LEVEL_W-1:0] LEVEL_TOP  = LEVEL_W'(MAX_LEVEL);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(SHOW_TICKS - 1);

  game_state_e        state_q, state_d;
  logic [SCORE_W-1:0] wins_q, wins_d;
  logic [SCORE_W-1:0] losses_q, losses_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               fsm_clear_q, fsm_clear_d;
  logic               fsm_en_q, fsm_en_d;
  logic               game_over_q, game_over_d;

  logic               play_tick;
  logic               div_clear;
  logic               div_tick;
  logic [LEVEL_W-1:0] div_ratio;

  // Divider only sees timebase pulses while a round is running; higher
  // levels shorten the ratio so the guess FSM steps faster.
  assign play_tick = bus.tick_in && (state_q == ST_PLAY);
  assign div_clear = (state_q == ST_CLEAR);
  assign div_ratio = LEVEL_TOP - level_q;

  tick_divider u_tick_divider (
    .clk      (clk),
    .rst      (rst),
    .tick_in  (play_tick),
    .ratio    (div_ratio),
    .clear    (div_clear),
    .tick_out (div_tick)
  );

  always_comb begin
    state_d     = state_q;
    wins_d      = wins_q;
    losses_d    = losses_q;
    lives_d     = lives_q;
    level_d     = level_q;
    hold_d      = hold_q;
    fsm_en_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start_tick) begin
          state_d = ST_CLEAR;
        end
      end

      ST_CLEAR: begin
        hold_d  = '0;
        state_d = ST_PLAY;
      end

      ST_PLAY: begin
        // win has priority; a simultaneous lose is dropped
        if (bus.win) begin
          wins_d  = sat_inc(wins_q);
          level_d = (level_q == LEVEL_TOP) ? level_q : level_q + LEVEL_W'(1);
          hold_d  = HOLD_LAST;
          state_d = ST_SHOW_WIN;
        end else if (bus.lose) begin
          losses_d = sat_inc(losses_q);
          lives_d  = (lives_q == '0) ? lives_q : lives_q - LIVES_W'(1);
          hold_d   = HOLD_LAST;
          state_d  = ST_SHOW_LOSE;
        end else begin
          fsm_en_d = div_tick;
        end
      end

      ST_SHOW_WIN, ST_SHOW_LOSE: begin
        // hold is a down-counter loaded on entry; terminal count 0 on a tick exits
        if (bus.tick_in) begin
          if (hold_q == '0) begin
            if (state_q == ST_SHOW_WIN || lives_q != '0) begin
              state_d = ST_CLEAR;
            end else begin
              state_d = ST_OVER;
            end
          end else begin
            hold_d = hold_q - HOLD_W'(1);
          end
        end
      end

      ST_OVER: begin
        if (bus.start_tick) begin
          wins_d   = '0;
          losses_d = '0;
          lives_d  = LIVES_INIT;
          level_d  = '0;
          state_d  = ST_CLEAR;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Registered outputs reflect the state being entered.
    fsm_clear_d = (state_d == ST_CLEAR);
    game_over_d = (state_d == ST_OVER);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wins_q      <= '0;
      losses_q    <= '0;
      lives_q     <= LIVES_INIT;
      level_q     <= '0;
      hold_q      <= '0;
      fsm_clear_q <= 1'b0;
      fsm_en_q    <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wins_q      <= wins_d;
      losses_q    <= losses_d;
      lives_q     <= lives_d;
      level_q     <= level_d;
      hold_q      <= hold_d;
      fsm_clear_q <= fsm_clear_d;
      fsm_en_q    <= fsm_en_d;
      game_over_q <= game_over_d;
    end
  end

  assign bus.fsm_clear = fsm_clear_q;
  assign bus.fsm_en    = fsm_en_q;
  assign bus.wins      = wins_q;
  assign bus.losses    = losses_q;
  assign bus.lives     = lives_q;
  assign bus.level     = level_q;
  assign bus.game_over = game_over_q;

endmodule
